pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Stall/flush sequencer for the five-stage MIPS pipeline. It drives the enable and clear pins of every inter-stage pipeline register (F/D, D/E, E/M, M/W) and the PC register. It detects load-use and branch-operand hazards, runs the start/ready handshake with the multi-cycle divider, freezes the pipeline during SRAM waits, and sequences precise exception/eret flushes, deferring them while a data SRAM access is outstanding. It sits beside the datapath and sends one enable/clear pair to each pipeline register.

## Interface
- no parameters (register widths fixed by the ISA: 5-bit register indices)
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- rs_d, rt_d  in  5  source registers of the instruction in D
- branch_d  in  1  D holds a branch that compares in D
- rs_e, rt_e  in  5  source registers in E
- writereg_e, writereg_m, writereg_w  in  5  destination registers
- regwrite_e, regwrite_m, regwrite_w  in  1  destination write enables
- memtoreg_e, memtoreg_m  in  1  load in E / M
- div_req_e  in  1  E holds div/divu
- div_ready  in  1  divider result valid, one-cycle pulse
- inst_stall, data_stall  in  1  instruction / data SRAM wait
- exc_m  in  1  exception or eret committed in M
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1  hold pipeline register (register ena = ~stall)
- flush_d, flush_e, flush_m, flush_w  out  1  clear pipeline register (register clr)
- exc_redirect  out  1  PC takes the exception/epc target this cycle
- div_start  out  1  one-cycle divider launch
- div_cancel  out  1  one-cycle divider abort
- forward_a_e, forward_b_e  out  2  E operand select: 00 regfile, 01 W, 10 M
- forward_a_d, forward_b_d  out  1  D branch comparator takes the M result

## Operation
- FSM states:
  - RUN: normal operation.
  - DIV_WAIT: divider busy.
  - EXC_WAIT: exception pending behind data_stall.
- Reset values: state RUN. All stalls 0. Flushes 1 while rst is high. exc_redirect 0. div_start 0. div_cancel 0. Forwards 0.
- Priority, highest first: exception > SRAM stall > divider > load-use/branch hazard.
- Exception, in RUN or DIV_WAIT:
  - If exc_m=1 and data_stall=0: assert flush_d, flush_e, flush_m, flush_w and exc_redirect in that cycle. Stay in or return to RUN.
  - If the state was DIV_WAIT, also pulse div_cancel.
- Exception deferred: if exc_m=1 and data_stall=1, enter EXC_WAIT.
  - In EXC_WAIT, freeze everything: all stalls 1, no flushes.
  - In the first cycle with data_stall=0, issue the full flush and exc_redirect, then go to RUN.
- SRAM stall: inst_stall or data_stall sets stall_f through stall_w to 1 and all flushes to 0. State is unchanged.
- Divider, RUN:
  - div_req_e=1 with no higher-priority event: pulse div_start, go to DIV_WAIT.
  - In that cycle and all of DIV_WAIT: stall_f, stall_d, stall_e = 1 and flush_m = 1 (bubble into M).
- Divider, DIV_WAIT:
  - In the div_ready cycle, release stalls so E advances, and return to RUN.
  - div_start must not re-fire for the same instruction.
- Load-use hazard: memtoreg_e & regwrite_e & writereg_e≠0 & (writereg_e==rs_d | writereg_e==rt_d) gives stall_f=1, stall_d=1, flush_e=1.
- Branch hazard: branch_d and a source matches writereg_e with regwrite_e, or matches writereg_m with memtoreg_m. Response is the same stall/bubble as load-use.
- Forwarding:
  - M has priority over W.
  - Register 0 is never forwarded.
  - A forward requires the matching regwrite.

## Timing
- All stall, flush, forward and exc_redirect outputs are combinational from the current state and inputs. They are valid in the same cycle.
- div_start and div_cancel are Moore-qualified pulses, exactly 1 cycle wide.
- Divide latency is N cycles between div_start and div_ready. The E-stage instruction is held for N+1 cycles.
- If div_ready arrives while inst_stall or data_stall is high, it is captured in a ready-seen flag. The release happens on the first unstalled cycle, and the flag clears on that release.
- If rst asserts mid-division, the FSM returns to RUN asynchronously. No div_cancel is needed because the divider shares rst.
- Simultaneous exc_m and div_ready: the exception wins, the div result is discarded, and div_cancel is not asserted.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state encoding (RUN, DIV_WAIT, EXC_WAIT);
  - forward select constants (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
- Sub-module hazard_detect (combinational) holds the comparators for load-use, branch and forwarding. pipeline_ctrl holds the FSM, the ready-seen flag and the priority mux.

## Test plan
- Load-use: lw $2 in E, add $3,$2,$4 in D → stall_f=1, stall_d=1, flush_e=1 for 1 cycle, then forward_a_e=01 when the add reaches E.
- Divide: div_req_e=1, div_ready after 32 cycles → one div_start pulse; stall_e=1 for 33 cycles; flush_m=1 throughout; state returns to RUN.
- Exception in DIV_WAIT: exc_m=1 at cycle 5 of the divide → all four flushes plus exc_redirect in that cycle, div_cancel pulse, state RUN.
- Deferred exception: exc_m=1 with data_stall=1 for 3 cycles → all stalls 1 for those cycles; flush plus redirect on cycle 4 only.
- Forward priority: writereg_m=writereg_w=5 and rs_e=5 → forward_a_e=10. With rs_e=0 → forward_a_e=00.
- Reset during DIV_WAIT: rst pulse → outputs return to their reset values immediately; no div_start after rst falls unless div_req_e is set.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline stall/flush sequencer.
//   state_e        - sequencer FSM encoding (run / divider wait / deferred exception)
//   FWD_*          - E-stage operand select codes
//   STALL_*/FLUSH_* - bit patterns for the packed stall {f,d,e,m,w} and flush {d,e,m,w} vectors
//   src_hit()      - register-match test shared by hazard and forwarding logic
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDivWait = 2'd1,
        StExcWait = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Packed as {f, d, e, m, w}
    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_FD   = 5'b11000;
    localparam logic [4:0] STALL_FDE  = 5'b11100;
    localparam logic [4:0] STALL_ALL  = 5'b11111;

    // Packed as {d, e, m, w}
    localparam logic [3:0] FLUSH_NONE = 4'b0000;
    localparam logic [3:0] FLUSH_E    = 4'b0100;
    localparam logic [3:0] FLUSH_M    = 4'b0010;
    localparam logic [3:0] FLUSH_ALL  = 4'b1111;

    // A source operand depends on a producer only if the producer writes a real register.
    function automatic logic src_hit(input logic [4:0] src, input logic [4:0] dst,
                                     input logic we);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: bundle between the datapath and the pipeline sequencer.
//   master - datapath side: drives register indices, write enables, divider and SRAM status,
//            and receives the stall/flush/forward controls.
//   slave  - sequencer side (pipeline_ctrl).
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    // Hazard / forwarding inputs
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       branch_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] writereg_e;
    logic [4:0] writereg_m;
    logic [4:0] writereg_w;
    logic       regwrite_e;
    logic       regwrite_m;
    logic       regwrite_w;
    logic       memtoreg_e;
    logic       memtoreg_m;

    // Divider, SRAM and exception status
    logic       div_req_e;
    logic       div_ready;
    logic       inst_stall;
    logic       data_stall;
    logic       exc_m;

    // Pipeline register controls
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_m;
    logic       stall_w;
    logic       flush_d;
    logic       flush_e;
    logic       flush_m;
    logic       flush_w;
    logic       exc_redirect;
    logic       div_start;
    logic       div_cancel;
    logic [1:0] forward_a_e;
    logic [1:0] forward_b_e;
    logic       forward_a_d;
    logic       forward_b_d;

    modport master (
        output rs_d, rt_d, branch_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
               regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
               div_req_e, div_ready, inst_stall, data_stall, exc_m,
        input  stall_f, stall_d, stall_e, stall_m, stall_w,
               flush_d, flush_e, flush_m, flush_w, exc_redirect, div_start, div_cancel,
               forward_a_e, forward_b_e, forward_a_d, forward_b_d
    );

    modport slave (
        input  rs_d, rt_d, branch_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
               regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
               div_req_e, div_ready, inst_stall, data_stall, exc_m,
        output stall_f, stall_d, stall_e, stall_m, stall_w,
               flush_d, flush_e, flush_m, flush_w, exc_redirect, div_start, div_cancel,
               forward_a_e, forward_b_e, forward_a_d, forward_b_d
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// pipeline_ctrl_hazard_detect: combinational register comparators.
//   rs_d_i/rt_d_i/branch_d_i            - instruction in D
//   rs_e_i/rt_e_i                       - sources in E
//   writereg_*_i/regwrite_*_i/memtoreg_*_i - producers in E, M, W
//   load_use_o    - load in E feeds an instruction in D
//   branch_hz_o   - D branch comparator needs a value not yet available
//   forward_*_e_o - E operand selects (M preferred over W)
//   forward_*_d_o - D branch operand takes the M result
module pipeline_ctrl_hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic       branch_d_i,
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rt_e_i,
    input  logic [4:0] writereg_e_i,
    input  logic [4:0] writereg_m_i,
    input  logic [4:0] writereg_w_i,
    input  logic       regwrite_e_i,
    input  logic       regwrite_m_i,
    input  logic       regwrite_w_i,
    input  logic       memtoreg_e_i,
    input  logic       memtoreg_m_i,
    output logic       load_use_o,
    output logic       branch_hz_o,
    output logic [1:0] forward_a_e_o,
    output logic [1:0] forward_b_e_o,
    output logic       forward_a_d_o,
    output logic       forward_b_d_o
);

    logic e_hits_d;
    logic m_load_hits_d;

    always_comb begin
        e_hits_d      = src_hit(rs_d_i, writereg_e_i, regwrite_e_i) ||
                        src_hit(rt_d_i, writereg_e_i, regwrite_e_i);
        // A load in M has no result yet for the D comparator, so only loads stall here.
        m_load_hits_d = src_hit(rs_d_i, writereg_m_i, memtoreg_m_i) ||
                        src_hit(rt_d_i, writereg_m_i, memtoreg_m_i);

        load_use_o  = memtoreg_e_i && e_hits_d;
        branch_hz_o = branch_d_i && (e_hits_d || m_load_hits_d);

        if (src_hit(rs_e_i, writereg_m_i, regwrite_m_i)) begin
            forward_a_e_o = FWD_M;
        end else if (src_hit(rs_e_i, writereg_w_i, regwrite_w_i)) begin
            forward_a_e_o = FWD_W;
        end else begin
            forward_a_e_o = FWD_RF;
        end

        if (src_hit(rt_e_i, writereg_m_i, regwrite_m_i)) begin
            forward_b_e_o = FWD_M;
        end else if (src_hit(rt_e_i, writereg_w_i, regwrite_w_i)) begin
            forward_b_e_o = FWD_W;
        end else begin
            forward_b_e_o = FWD_RF;
        end

        forward_a_d_o = src_hit(rs_d_i, writereg_m_i, regwrite_m_i);
        forward_b_d_o = src_hit(rt_d_i, writereg_m_i, regwrite_m_i);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage pipeline.
//   clk  - pipeline clock
//   rst  - asynchronous reset, active-high
//   bus  - pipeline_ctrl_if.slave: hazard inputs, divider/SRAM/exception status in;
//          per-stage stall/flush, exc_redirect, div_start/div_cancel pulses and forwards out.
// Priority, highest first: exception > SRAM stall > divider > load-use/branch hazard.
// div_start/div_cancel are registered one-cycle pulses; everything else is combinational.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    state_e state_q, state_d;
    logic   div_start_q, div_start_d;
    logic   div_cancel_q, div_cancel_d;
    // div_ready arrived while the pipeline was frozen; release on the next free cycle.
    logic   ready_seen_q, ready_seen_d;
    // Divider still running behind a deferred exception; cancel it when the flush issues.
    logic   exc_div_q, exc_div_d;

    logic       load_use;
    logic       branch_hz;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       fwd_a_d;
    logic       fwd_b_d;

    logic       sram_stall;
    logic       div_busy;
    logic       div_done;
    logic [4:0] stall;
    logic [3:0] flush;
    logic       redirect;

    pipeline_ctrl_hazard_detect u_hazard_detect (
        .rs_d_i        (bus.rs_d),
        .rt_d_i        (bus.rt_d),
        .branch_d_i    (bus.branch_d),
        .rs_e_i        (bus.rs_e),
        .rt_e_i        (bus.rt_e),
        .writereg_e_i  (bus.writereg_e),
        .writereg_m_i  (bus.writereg_m),
        .writereg_w_i  (bus.writereg_w),
        .regwrite_e_i  (bus.regwrite_e),
        .regwrite_m_i  (bus.regwrite_m),
        .regwrite_w_i  (bus.regwrite_w),
        .memtoreg_e_i  (bus.memtoreg_e),
        .memtoreg_m_i  (bus.memtoreg_m),
        .load_use_o    (load_use),
        .branch_hz_o   (branch_hz),
        .forward_a_e_o (fwd_a_e),
        .forward_b_e_o (fwd_b_e),
        .forward_a_d_o (fwd_a_d),
        .forward_b_d_o (fwd_b_d)
    );

    always_comb begin
        sram_stall = bus.inst_stall || bus.data_stall;
        div_done   = bus.div_ready || ready_seen_q;
        // Only a divider that has not yet produced its result needs an abort.
        div_busy   = (state_q == StDivWait) && !div_done;

        state_d      = state_q;
        div_start_d  = 1'b0;
        div_cancel_d = 1'b0;
        ready_seen_d = ready_seen_q;
        exc_div_d    = exc_div_q;
        stall        = STALL_NONE;
        flush        = FLUSH_NONE;
        redirect     = 1'b0;

        unique case (state_q)
            StRun, StDivWait: begin
                if (bus.exc_m && !bus.data_stall) begin
                    flush        = FLUSH_ALL;
                    redirect     = 1'b1;
                    div_cancel_d = div_busy;
                    ready_seen_d = 1'b0;
                    exc_div_d    = 1'b0;
                    state_d      = StRun;
                end else if (bus.exc_m) begin
                    // Data access in flight: hold M so the flush stays precise.
                    stall        = STALL_ALL;
                    exc_div_d    = div_busy;
                    ready_seen_d = 1'b0;
                    state_d      = StExcWait;
                end else if (sram_stall) begin
                    stall = STALL_ALL;
                    if ((state_q == StDivWait) && bus.div_ready) begin
                        ready_seen_d = 1'b1;
                    end
                end else if ((state_q == StDivWait) && !div_done) begin
                    stall = STALL_FDE;
                    flush = FLUSH_M;
                end else if ((state_q == StRun) && bus.div_req_e) begin
                    stall       = STALL_FDE;
                    flush       = FLUSH_M;
                    div_start_d = 1'b1;
                    state_d     = StDivWait;
                end else begin
                    // Normal flow, or the divide release cycle where E advances.
                    state_d      = StRun;
                    ready_seen_d = 1'b0;
                    if (load_use || branch_hz) begin
                        stall = STALL_FD;
                        flush = FLUSH_E;
                    end
                end
            end
            StExcWait: begin
                if (bus.data_stall) begin
                    stall = STALL_ALL;
                    if (bus.div_ready) begin
                        exc_div_d = 1'b0;
                    end
                end else begin
                    flush        = FLUSH_ALL;
                    redirect     = 1'b1;
                    div_cancel_d = exc_div_q && !bus.div_ready;
                    exc_div_d    = 1'b0;
                    state_d      = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            div_start_q  <= 1'b0;
            div_cancel_q <= 1'b0;
            ready_seen_q <= 1'b0;
            exc_div_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_start_q  <= div_start_d;
            div_cancel_q <= div_cancel_d;
            ready_seen_q <= ready_seen_d;
            exc_div_q    <= exc_div_d;
        end
    end

    // Reset clears every pipeline register and keeps the PC still.
    always_comb begin
        bus.stall_f      = rst ? 1'b0 : stall[4];
        bus.stall_d      = rst ? 1'b0 : stall[3];
        bus.stall_e      = rst ? 1'b0 : stall[2];
        bus.stall_m      = rst ? 1'b0 : stall[1];
        bus.stall_w      = rst ? 1'b0 : stall[0];
        bus.flush_d      = rst ? 1'b1 : flush[3];
        bus.flush_e      = rst ? 1'b1 : flush[2];
        bus.flush_m      = rst ? 1'b1 : flush[1];
        bus.flush_w      = rst ? 1'b1 : flush[0];
        bus.exc_redirect = rst ? 1'b0 : redirect;
        bus.forward_a_e  = rst ? FWD_RF : fwd_a_e;
        bus.forward_b_e  = rst ? FWD_RF : fwd_b_e;
        bus.forward_a_d  = rst ? 1'b0 : fwd_a_d;
        bus.forward_b_d  = rst ? 1'b0 : fwd_b_d;
        bus.div_start    = div_start_q;
        bus.div_cancel   = div_cancel_q;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl. Each stimulus cycle pushes the
// expected output vector; a negedge monitor pops and compares it against the DUT.
// Vector layout: {stall f,d,e,m,w, flush d,e,m,w, redirect, start, cancel, fa_e, fb_e, fa_d, fb_d}
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic clk;
    logic rst;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] exp_q[$];
    string       tag_q[$];
    logic [17:0] act;

    assign act = {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.stall_w,
                  bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w,
                  bus.exc_redirect, bus.div_start, bus.div_cancel,
                  bus.forward_a_e, bus.forward_b_e, bus.forward_a_d, bus.forward_b_d};

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %05h want %05h", tag, got, want);
        end
    endtask

    function automatic logic [17:0] mk(input logic [4:0] s, input logic [3:0] f,
                                       input logic r, input logic st, input logic c,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic fad, input logic fbd);
        return {s, f, r, st, c, fa, fb, fad, fbd};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check_eq(tag_q.pop_front(), act, exp_q.pop_front());
        end
    end

    task automatic clr();
        bus.rs_d = 0; bus.rt_d = 0; bus.branch_d = 0; bus.rs_e = 0; bus.rt_e = 0;
        bus.writereg_e = 0; bus.writereg_m = 0; bus.writereg_w = 0;
        bus.regwrite_e = 0; bus.regwrite_m = 0; bus.regwrite_w = 0;
        bus.memtoreg_e = 0; bus.memtoreg_m = 0;
        bus.div_req_e = 0; bus.div_ready = 0; bus.inst_stall = 0; bus.data_stall = 0;
        bus.exc_m = 0;
    endtask

    // Inputs are already set; queue the expectation and move to the next cycle.
    task automatic step(input string tag, input logic [17:0] want);
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    logic [17:0] zero_v;
    logic [17:0] div_v;
    logic [17:0] all_stall_v;
    logic [17:0] exc_v;
    logic [17:0] cancel_v;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_v      = mk(STALL_NONE, FLUSH_NONE, 0, 0, 0, FWD_RF, FWD_RF, 0, 0);
        div_v       = mk(STALL_FDE, FLUSH_M, 0, 0, 0, FWD_RF, FWD_RF, 0, 0);
        all_stall_v = mk(STALL_ALL, FLUSH_NONE, 0, 0, 0, FWD_RF, FWD_RF, 0, 0);
        exc_v       = mk(STALL_NONE, FLUSH_ALL, 1, 0, 0, FWD_RF, FWD_RF, 0, 0);
        cancel_v    = mk(STALL_NONE, FLUSH_NONE, 0, 0, 1, FWD_RF, FWD_RF, 0, 0);

        rst = 1'b1;
        clr();
        @(posedge clk);
        #1;

        // Reset: forwarding-shaped inputs must still read as 0
        bus.rs_e = 5; bus.writereg_m = 5; bus.regwrite_m = 1; bus.div_req_e = 1;
        step("reset", mk(STALL_NONE, FLUSH_ALL, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));
        rst = 1'b0; clr();
        step("idle", zero_v);

        // Load-use: lw $2 in E, add $3,$2,$4 in D
        bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.writereg_e = 2; bus.rs_d = 2; bus.rt_d = 4;
        step("load_use", mk(STALL_FD, FLUSH_E, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));
        clr();
        bus.regwrite_m = 1; bus.memtoreg_m = 1; bus.writereg_m = 2; bus.rs_d = 2; bus.rt_d = 4;
        step("load_use_bubble", mk(STALL_NONE, FLUSH_NONE, 0, 0, 0, FWD_RF, FWD_RF, 1, 0));
        clr();
        bus.rs_e = 2; bus.rt_e = 4; bus.regwrite_w = 1; bus.writereg_w = 2;
        step("load_use_fwd_w", mk(STALL_NONE, FLUSH_NONE, 0, 0, 0, FWD_W, FWD_RF, 0, 0));
        clr();
        bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.writereg_e = 0; bus.rs_d = 0;
        step("load_use_r0", zero_v);

        // Forwarding priority and register 0
        clr();
        bus.writereg_m = 5; bus.writereg_w = 5; bus.regwrite_m = 1; bus.regwrite_w = 1;
        bus.rs_e = 5; bus.rt_e = 5;
        step("fwd_m_prio", mk(STALL_NONE, FLUSH_NONE, 0, 0, 0, FWD_M, FWD_M, 0, 0));
        bus.writereg_m = 0; bus.writereg_w = 0; bus.rs_e = 0; bus.rt_e = 0;
        step("fwd_r0", zero_v);
        bus.writereg_m = 5; bus.regwrite_m = 0; bus.writereg_w = 5; bus.rs_e = 5;
        bus.rt_e = 7;
        step("fwd_need_we", mk(STALL_NONE, FLUSH_NONE, 0, 0, 0, FWD_W, FWD_RF, 0, 0));

        // Branch hazards
        clr();
        bus.branch_d = 1; bus.rs_d = 8; bus.regwrite_e = 1; bus.writereg_e = 8;
        step("branch_e", mk(STALL_FD, FLUSH_E, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));
        clr();
        bus.branch_d = 1; bus.rt_d = 9; bus.memtoreg_m = 1; bus.regwrite_m = 1;
        bus.writereg_m = 9;
        step("branch_m_load", mk(STALL_FD, FLUSH_E, 0, 0, 0, FWD_RF, FWD_RF, 0, 1));
        clr();
        bus.rs_d = 8; bus.regwrite_e = 1; bus.writereg_e = 8;
        step("no_branch_alu", zero_v);

        // SRAM stall overrides a load-use hazard
        clr();
        bus.inst_stall = 1; bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.writereg_e = 3;
        bus.rs_d = 3;
        step("sram_stall", all_stall_v);

        // Divide with N = 32
        clr();
        bus.div_req_e = 1;
        step("div_req", div_v);
        for (int i = 1; i <= 32; i++) begin
            step("div_wait", mk(STALL_FDE, FLUSH_M, 0, (i == 1), 0, FWD_RF, FWD_RF, 0, 0));
        end
        bus.div_ready = 1;
        step("div_release", zero_v);
        clr();
        step("div_done", zero_v);
        step("div_idle", zero_v);

        // div_ready during a data stall is held until the first free cycle
        bus.div_req_e = 1;
        step("divs_req", div_v);
        step("divs_start", mk(STALL_FDE, FLUSH_M, 0, 1, 0, FWD_RF, FWD_RF, 0, 0));
        step("divs_wait", div_v);
        bus.data_stall = 1; bus.div_ready = 1;
        step("divs_ready_stall", all_stall_v);
        bus.div_ready = 0;
        step("divs_stall", all_stall_v);
        bus.data_stall = 0;
        step("divs_release", zero_v);
        clr();
        step("divs_idle", zero_v);

        // Exception in cycle 5 of a divide
        bus.div_req_e = 1;
        step("dive_req", div_v);
        for (int i = 1; i <= 4; i++) begin
            step("dive_wait", mk(STALL_FDE, FLUSH_M, 0, (i == 1), 0, FWD_RF, FWD_RF, 0, 0));
        end
        bus.exc_m = 1;
        step("dive_exc", exc_v);
        clr();
        step("dive_cancel", cancel_v);
        step("dive_idle", zero_v);

        // Exception together with div_ready: no cancel
        bus.div_req_e = 1;
        step("divr_req", div_v);
        step("divr_start", mk(STALL_FDE, FLUSH_M, 0, 1, 0, FWD_RF, FWD_RF, 0, 0));
        step("divr_wait", div_v);
        bus.exc_m = 1; bus.div_ready = 1;
        step("divr_exc", exc_v);
        clr();
        step("divr_no_cancel", zero_v);

        // Deferred exception from RUN
        bus.exc_m = 1; bus.data_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step("exc_defer", all_stall_v);
        end
        bus.data_stall = 0;
        step("exc_issue", exc_v);
        clr();
        step("exc_after", zero_v);

        // Deferred exception from DIV_WAIT cancels the divider on issue
        bus.div_req_e = 1;
        step("divx_req", div_v);
        step("divx_start", mk(STALL_FDE, FLUSH_M, 0, 1, 0, FWD_RF, FWD_RF, 0, 0));
        bus.exc_m = 1; bus.data_stall = 1;
        step("divx_defer", all_stall_v);
        bus.data_stall = 0;
        step("divx_issue", exc_v);
        clr();
        step("divx_cancel", cancel_v);
        step("divx_idle", zero_v);

        // Exception beats SRAM stall and a divide request in RUN
        bus.exc_m = 1; bus.inst_stall = 1; bus.div_req_e = 1;
        step("exc_over_all", exc_v);
        clr();
        step("exc_no_start", zero_v);

        // Reset in the middle of a divide
        bus.div_req_e = 1;
        step("divrst_req", div_v);
        rst = 1'b1;
        step("divrst_reset", mk(STALL_NONE, FLUSH_ALL, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));
        rst = 1'b0; clr();
        step("divrst_after", zero_v);
        step("divrst_no_start", zero_v);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
